// File: rtl/tt_maquina_pkg.sv
// Shared definitions between the lever command generator and the gear-selector
// FSM: position encoding, selector state encoding and the brake interlock rule.
package tt_maquina_pkg;

    // Position encoding, identical to the selector FSM's {M1,M0} state
    localparam logic [1:0] EST_P = 2'b00;
    localparam logic [1:0] EST_N = 2'b01;
    localparam logic [1:0] EST_R = 2'b10;
    localparam logic [1:0] EST_D = 2'b11;

    typedef enum logic [1:0] {
        ESPERA = 2'b00,
        FILTRO = 2'b01,
        VALIDA = 2'b10
    } sel_estado_e;

    // Brake interlock: entering Park is always safe; leaving Park and the
    // direct Reverse/Drive swaps need the brake pressed.
    function automatic logic permitido(input logic [1:0] origen,
                                       input logic [1:0] destino,
                                       input logic       freno);
        logic ok;
        if (destino == EST_P) begin
            ok = 1'b1;
        end else if (origen == EST_P) begin
            ok = freno;
        end else if ((origen == EST_R && destino == EST_D) ||
                     (origen == EST_D && destino == EST_R)) begin
            ok = freno;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    // One-hot command vector {D,R,N,P} for a position
    function automatic logic [3:0] pulso_de(input logic [1:0] pos);
        return 4'b0001 << pos;
    endfunction

endpackage

// File: rtl/tt_sincronizador.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module tt_sincronizador #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two register stages to resolve metastability on the raw contacts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tt_selector_palanca.sv
// Gear lever command generator: synchronizes and debounces the four lever
// contacts, applies the brake interlock and issues one-cycle P/N/R/D pulses
// to the selector FSM. Optional macro SELECTOR_REINTENTO_EN re-emits the
// accepted position's pulse when the FSM feedback stays out of step for
// 32 cycles while idle.
module tt_selector_palanca
    import tt_maquina_pkg::*;
#(
    parameter  int DEB_CYCLES = 16,
    localparam int DEB_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lever_p,
    input  logic       lever_n,
    input  logic       lever_r,
    input  logic       lever_d,
    input  logic       freno,
    input  logic [1:0] estado_fsm,
    output logic       P,
    output logic       N,
    output logic       R,
    output logic       D,
    output logic       rechazo,
    output logic       invalido,
    output logic       sincronizado
);

    logic [3:0]       lev_sync;
    logic             cand_vld;
    logic [1:0]       cand_pos;

    sel_estado_e      state_q;
    logic [1:0]       pos_ok_q;
    logic [1:0]       pos_cand_q;
    logic [DEB_W-1:0] cnt_q;
    logic [3:0]       pulse_q;
    logic             rechazo_q;
    logic             invalido_q;
    logic             blk_vld_q;
    logic [1:0]       blk_pos_q;
`ifdef SELECTOR_REINTENTO_EN
    localparam int    REINT_CICLOS = 32;
    logic [4:0]       reint_q;
`endif

    tt_sincronizador #(
        .WIDTH(4)
    ) u_sincronizador (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    ({lever_d, lever_r, lever_n, lever_p}),
        .q_o    (lev_sync)
    );

    // Decode: exactly one synced contact names a candidate position
    always_comb begin
        cand_vld = 1'b1;
        cand_pos = EST_P;
        case (lev_sync)
            4'b0001: cand_pos = EST_P;
            4'b0010: cand_pos = EST_N;
            4'b0100: cand_pos = EST_R;
            4'b1000: cand_pos = EST_D;
            default: cand_vld = 1'b0;
        endcase
    end

    // Debounce / interlock FSM with registered command and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ESPERA;
            pos_ok_q   <= EST_P;
            pos_cand_q <= EST_P;
            cnt_q      <= '0;
            pulse_q    <= '0;
            rechazo_q  <= 1'b0;
            invalido_q <= 1'b0;
            blk_vld_q  <= 1'b0;
            blk_pos_q  <= EST_P;
`ifdef SELECTOR_REINTENTO_EN
            reint_q    <= '0;
`endif
        end else begin
            pulse_q    <= '0;
            invalido_q <= !cand_vld;
`ifdef SELECTOR_REINTENTO_EN
            reint_q    <= '0;
`endif
            // A blocked position is forgotten as soon as the lever moves off it
            if (blk_vld_q && (!cand_vld || cand_pos != blk_pos_q)) begin
                blk_vld_q <= 1'b0;
            end
            case (state_q)
                ESPERA: begin
                    if (cand_vld && cand_pos != pos_ok_q &&
                        !(blk_vld_q && cand_pos == blk_pos_q)) begin
                        pos_cand_q <= cand_pos;
                        cnt_q      <= DEB_W'(1);
                        state_q    <= FILTRO;
                    end else begin
                        cnt_q <= '0;
`ifdef SELECTOR_REINTENTO_EN
                        if (!sincronizado) begin
                            if (reint_q == 5'(REINT_CICLOS - 1)) begin
                                pulse_q <= pulso_de(pos_ok_q);
                                reint_q <= '0;
                            end else begin
                                reint_q <= reint_q + 5'd1;
                            end
                        end
`endif
                    end
                end
                FILTRO: begin
                    if (cand_vld && cand_pos == pos_cand_q) begin
                        cnt_q <= cnt_q + DEB_W'(1);
                        if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                            state_q <= VALIDA;
                        end
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ESPERA;
                    end
                end
                VALIDA: begin
                    if (permitido(pos_ok_q, pos_cand_q, freno)) begin
                        pos_ok_q  <= pos_cand_q;
                        pulse_q   <= pulso_de(pos_cand_q);
                        rechazo_q <= 1'b0;
                    end else begin
                        rechazo_q <= 1'b1;
                        blk_vld_q <= 1'b1;
                        blk_pos_q <= pos_cand_q;
                    end
                    cnt_q   <= '0;
                    state_q <= ESPERA;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ESPERA;
                end
            endcase
        end
    end

    assign P            = pulse_q[0];
    assign N            = pulse_q[1];
    assign R            = pulse_q[2];
    assign D            = pulse_q[3];
    assign rechazo      = rechazo_q;
    assign invalido     = invalido_q;
    assign sincronizado = (estado_fsm == pos_ok_q);

endmodule

// File: tb/tb_tt_selector_palanca.sv
// Scoreboard bench for the lever command generator. Stimulus is issued as
// segments of constant lever contacts; a segment-level model predicts each
// accept/reject decision and its cycle, and a monitor compares on every DUT
// pulse or expected decision time.
module tb_tt_selector_palanca;

    localparam int DEB      = 16;
    localparam int LONG_MIN = 24;
    localparam int HN       = 8192;
    localparam logic [1:0] TP = 2'b00, TN = 2'b01, TR = 2'b10, TD = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lever_p = 1'b0, lever_n = 1'b0, lever_r = 1'b0, lever_d = 1'b0;
    logic       freno = 1'b0;
    logic [1:0] estado_fsm = 2'b00;
    logic       P, N, R, D, rechazo, invalido, sincronizado;

    tt_selector_palanca #(.DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset_n(reset_n),
        .lever_p(lever_p), .lever_n(lever_n), .lever_r(lever_r), .lever_d(lever_d),
        .freno(freno), .estado_fsm(estado_fsm),
        .P(P), .N(N), .R(R), .D(D),
        .rechazo(rechazo), .invalido(invalido), .sincronizado(sincronizado)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        logic       rech;
        logic [1:0] pos_ok;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    int         inv_from = 0;
    logic [1:0] exp_pos_ok = TP;
    logic       exp_rech = 1'b0;
    logic [3:0] rec[HN];

    // model state
    logic [1:0] m_pos_ok = TP;
    bit         prev_short = 1'b0;
    bit         prev_valid = 1'b0;
    logic [1:0] prev_pos = TP;
    logic [3:0] prev_vec = 4'b0000;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    function automatic logic [1:0] pos_of(input logic [3:0] v);
        case (v)
            4'b0010: return TN;
            4'b0100: return TR;
            4'b1000: return TD;
            default: return TP;
        endcase
    endfunction

    // Brake is needed to leave Park, or to swap directly between R and D
    function automatic bit needs_brake(input logic [1:0] src, input logic [1:0] dst);
        if (dst == TP) return 1'b0;
        if (src == TP) return 1'b1;
        return (src == TR && dst == TD) || (src == TD && dst == TR);
    endfunction

    // Hold one lever pattern for len cycles; predict its decision (if any)
    task automatic seg(input logic [3:0] vec, input int len, input logic fr, input int fr_flip);
        int         s;
        int         t;
        bit         valid;
        bit         dly;
        logic [1:0] pos;
        {lever_d, lever_r, lever_n, lever_p} = vec;
        freno = fr;
        s     = cyc;
        valid = $onehot(vec);
        pos   = pos_of(vec);
        // a different candidate still being filtered costs one extra cycle
        dly   = prev_short && prev_valid && (prev_pos != m_pos_ok);
        if (len >= LONG_MIN && valid && pos != m_pos_ok) begin
            t = s + 2 + DEB + 1 + int'(dly);
            if (needs_brake(m_pos_ok, pos) && !fr) begin
                evq.push_back('{t, 4'b0000, 1'b1, m_pos_ok});
            end else begin
                evq.push_back('{t, 4'(1) << pos, 1'b0, pos});
                m_pos_ok = pos;
            end
        end
        prev_short = (len < LONG_MIN);
        prev_valid = valid;
        prev_pos   = pos;
        prev_vec   = vec;
        for (int i = 0; i < len; i++) begin
            if (fr_flip > 0 && i == fr_flip) freno = !fr;
            if ($urandom_range(7) == 0) estado_fsm = 2'($urandom_range(3));
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on any pulse or when a decision is due
    initial begin
        logic [3:0] pul;
        logic [3:0] prev_pul;
        ev_t        e;
        prev_pul = 4'b0000;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                pul = {D, R, N, P};
                rec[cyc % HN] = {lever_d, lever_r, lever_n, lever_p};
                if (pul != 4'b0000 || (evq.size() != 0 && evq[0].cyc <= cyc)) begin
                    if (evq.size() == 0) begin
                        chk("unexpected_pulse", 32'(pul), 32'(0));
                    end else begin
                        e = evq.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("pulse", 32'(pul), 32'(e.pulse));
                        chk("rechazo_at_event", 32'(rechazo), 32'(e.rech));
                        exp_pos_ok = e.pos_ok;
                        exp_rech   = e.rech;
                    end
                    if (pul != 4'b0000) chk("back_to_back", 32'(prev_pul != 4'b0000), 32'(0));
                end
                chk("rechazo", 32'(rechazo), 32'(exp_rech));
                if (cyc >= inv_from)
                    chk("invalido", 32'(invalido), 32'(!$onehot(rec[(cyc - 3) % HN])));
                chk("sincronizado", 32'(sincronizado), 32'(estado_fsm == exp_pos_ok));
                prev_pul = pul;
            end
        end
    end

    initial begin
        logic [3:0] v;
        logic [3:0] vec;
        bit         bad;
        int         len;
        estado_fsm = TP;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_pulses", 32'({D, R, N, P}), 32'(0));
        chk("reset_rechazo", 32'(rechazo), 32'(0));
        chk("reset_invalido", 32'(invalido), 32'(0));
        chk("reset_sincronizado", 32'(sincronizado), 32'(1));
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_invalido", 32'(invalido), 32'(1));
        chk("idle_pulses", 32'({D, R, N, P}), 32'(0));
        chk("idle_sincronizado", 32'(sincronizado), 32'(1));
        inv_from = cyc + 3;
        mon_en   = 1'b1;

        // directed scenarios
        seg(4'b0010, 30, 1'b1, 0);        // P->N with brake: N pulse
        seg(4'b0001, 30, 1'b0, 0);        // N->P: always allowed
        seg(4'b0010, 30, 1'b0, 0);        // P->N without brake: blocked
        seg(4'b0001, 30, 1'b1, 0);        // back to P: no request
        seg(4'b0010, 30, 1'b1, 0);        // P->N with brake: N pulse
        for (int i = 0; i < 4; i++) begin // bouncing Drive contact
            seg(4'b1000, 5, 1'b1, 0);
            seg(4'b0000, 5, 1'b1, 0);
        end
        seg(4'b1000, 30, 1'b1, 0);        // settles: D pulse
        seg(4'b0100, 60, 1'b0, 30);       // D->R blocked, brake later: still no re-request
        seg(4'b0001, 30, 1'b0, 0);        // D->P without brake: allowed
        seg(4'b1100, 30, 1'b1, 0);        // two contacts: invalid
        seg(4'b0100, 6, 1'b1, 0);         // short R glitch, then N
        seg(4'b0010, 30, 1'b1, 0);

        // randomized segments
        for (int k = 0; k < 120; k++) begin
            do begin
                if ($urandom_range(9) < 7) begin
                    vec = 4'(1) << $urandom_range(3);
                end else begin
                    do v = 4'($urandom_range(15)); while ($onehot(v));
                    vec = v;
                end
            end while (vec == prev_vec);
            len = ($urandom_range(1) == 1) ? int'($urandom_range(3, 8))
                                           : int'($urandom_range(LONG_MIN, 36));
            seg(vec, len, 1'($urandom_range(1)), 0);
        end
        seg(4'b0000, 6, 1'b0, 0);
        chk("pending_events", evq.size(), 0);

        // reset while filtering a new position
        mon_en     = 1'b0;
        estado_fsm = TP;
        {lever_d, lever_r, lever_n, lever_p} = 4'(1) << (m_pos_ok ^ 2'b01);
        freno = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_pulses", 32'({D, R, N, P}), 32'(0));
        chk("midreset_rechazo", 32'(rechazo), 32'(0));
        chk("midreset_invalido", 32'(invalido), 32'(0));
        chk("midreset_sincronizado", 32'(sincronizado), 32'(1));
        bad = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if ({D, R, N, P} != 4'b0000) bad = 1'b1;
        end
        chk("midreset_no_pulse", 32'(bad), 32'(0));
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
